pc_unit: RTL and testbench

- Program-counter stage directly downstream of the PC source selector.
- Holds the architectural PC and gates each write: unconditional writes, or conditional writes decided from branch type and ALU flags.
- Owns EPC capture and a small exception-entry sequencer. The sequencer fetches the handler address byte from memory and loads it into PC.
- Sole producer of the PC value consumed by fetch, ALU operand muxes and the selector's EPC input.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/branch_cond.sv | 29 ++
 rtl/pc_unit.sv | 155 +++++++++++++++
 tb/tb_pc_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared encodings for the CPU datapath and control slice:
//   - branch_op encodings used by branch_cond and the control unit
//   - exception cause encodings
//   - exception-entry sequencer states used by pc_unit
//   - default byte address of the first exception vector byte
package cpu_pkg;

    // Branch comparison selected by control for conditional PC writes
    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLE = 2'b10,
        BR_BGT = 2'b11
    } br_op_e;

    // Exception cause; EXC_RSVD is serviced as EXC_OPCODE
    typedef enum logic [1:0] {
        EXC_OPCODE = 2'b00,
        EXC_OVF    = 2'b01,
        EXC_DIV0   = 2'b10,
        EXC_RSVD   = 2'b11
    } exc_cause_e;

    // Exception-entry sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        LOAD = 2'b11
    } exc_state_e;

    // Vector bytes live at DEFAULT_VEC_BASE + cause (253, 254, 255)
    localparam logic [31:0] DEFAULT_VEC_BASE = 32'd253;

endpackage

// File: rtl/branch_cond.sv
// branch_cond
// Combinational branch decision shared by pc_unit and the control unit.
// Ports:
//   branch_op  in  2  BR_BEQ / BR_BNE / BR_BLE / BR_BGT
//   zero       in  1  ALU zero flag
//   gt         in  1  ALU greater-than flag
//   take       out 1  branch condition holds
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] branch_op,
    input  logic       zero,
    input  logic       gt,
    output logic       take
);

    // ble is "not greater than", so it only looks at the gt flag
    always_comb begin
        take = 1'b0;
        case (branch_op)
            BR_BEQ: take = zero;
            BR_BNE: take = ~zero;
            BR_BLE: take = ~gt;
            BR_BGT: take = gt;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit
// Program-counter stage: holds the architectural PC, gates unconditional
// and conditional (branch) writes, captures EPC and runs the exception-entry
// sequence that fetches the handler address byte from memory into PC.
// Optional build macro: PC_UNIT_ALIGN_CHECK_EN suppresses misaligned IDLE
// writes and pulses align_err; without it align_err is tied low.
// Ports:
//   clk            in  1   system clock, rising edge
//   reset          in  1   asynchronous active-high reset
//   pc_next        in  32  candidate PC from the PC source selector
//   pc_write       in  1   unconditional write strobe (priority)
//   pc_write_cond  in  1   conditional write strobe for branches
//   branch_op      in  2   branch comparison
//   zero, gt       in  1   ALU flags
//   exc_req        in  1   exception request pulse
//   exc_cause      in  2   exception cause
//   vec_byte       in  8   memory read data, low byte
//   vec_rd         out 1   vector byte read request (one cycle)
//   vec_addr       out 32  vector byte address
//   pc             out 32  current program counter
//   epc            out 32  exception PC
//   exc_busy       out 1   exception entry sequence in progress
//   align_err      out 1   misaligned write pulse
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EPC_OFFSET = 32'd4,
    parameter logic [31:0] VEC_BASE   = DEFAULT_VEC_BASE,
    parameter int          MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_op,
    input  logic        zero,
    input  logic        gt,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    input  logic [7:0]  vec_byte,
    output logic        vec_rd,
    output logic [31:0] vec_addr,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        exc_busy,
    output logic        align_err
);

    exc_state_e state;
    exc_state_e state_nxt;
    logic [2:0] lat_cnt;
    logic       take;
    logic       write_req;
    logic       misaligned;
    logic [1:0] cause_eff;

    branch_cond u_branch_cond (
        .branch_op (branch_op),
        .zero      (zero),
        .gt        (gt),
        .take      (take)
    );

    // pc_write wins over the branch decision when both strobes are high
    assign write_req = pc_write | (pc_write_cond & take);

`ifdef PC_UNIT_ALIGN_CHECK_EN
    assign misaligned = write_req & (pc_next[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The reserved cause shares the invalid-opcode vector
    assign cause_eff = (exc_cause == EXC_RSVD) ? EXC_OPCODE : exc_cause;

    assign exc_busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // REQ plus the WAIT cycles span MEM_LAT cycles, so vec_byte is valid
    // during LOAD. WAIT lasts MEM_LAT-1 cycles; lat_cnt enters WAIT at
    // MEM_LAT-1 and the last WAIT cycle is the one where it reads 1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (exc_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = (MEM_LAT <= 1) ? LOAD : WAIT;
            end
            WAIT: begin
                if (lat_cnt <= 3'd1) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers. vec_rd is raised on the edge that enters REQ so it
    // is high for exactly the REQ cycle; vec_addr then holds the latched cause.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            epc       <= 32'h0000_0000;
            lat_cnt   <= 3'd0;
            vec_rd    <= 1'b0;
            vec_addr  <= 32'h0000_0000;
            align_err <= 1'b0;
        end else begin
            vec_rd    <= 1'b0;
            align_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_req) begin
                        epc      <= pc - EPC_OFFSET;
                        vec_rd   <= 1'b1;
                        vec_addr <= VEC_BASE + {30'b0, cause_eff};
                    end else if (write_req) begin
                        if (misaligned) begin
                            align_err <= 1'b1;
                        end else begin
                            pc <= pc_next;
                        end
                    end
                end
                REQ: begin
                    lat_cnt <= 3'(MEM_LAT - 1);
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                end
                LOAD: begin
                    pc <= {24'b0, vec_byte};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit
// Self-checking bench for pc_unit: directed scenarios with hand-computed
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model that tracks the exception sequence by age.
module tb_pc_unit;

    localparam int          MEM_LAT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PC_UNIT_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_op;
    logic        zero;
    logic        gt;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [7:0]  vec_byte;
    logic        vec_rd;
    logic [31:0] vec_addr;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exc_busy;
    logic        align_err;

    int testsRun = 0;
    int testsFailed = 0;

    // Behavioural model state; age counts cycles since the exception was
    // accepted (0 = no sequence running)
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_vec_addr;
    logic        m_vec_rd;
    logic        m_align;
    logic [1:0]  m_cause;
    int          m_age;

    logic [7:0]  mem [0:2];
    logic        rd_hist [0:7];

    pc_unit #(
        .RESET_PC   (RESET_PC),
        .EPC_OFFSET (32'd4),
        .VEC_BASE   (32'd253),
        .MEM_LAT    (MEM_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_op     (branch_op),
        .zero          (zero),
        .gt            (gt),
        .exc_req       (exc_req),
        .exc_cause     (exc_cause),
        .vec_byte      (vec_byte),
        .vec_rd        (vec_rd),
        .vec_addr      (vec_addr),
        .pc            (pc),
        .epc           (epc),
        .exc_busy      (exc_busy),
        .align_err     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    // Branch truth from the instruction semantics
    function automatic logic modelTake(input logic [1:0] op, input logic z, input logic g);
        case (op)
            2'd0: return z;
            2'd1: return !z;
            2'd2: return !g;
            default: return g;
        endcase
    endfunction

    task automatic modelReset();
        m_pc       = RESET_PC;
        m_epc      = 32'h0;
        m_vec_addr = 32'h0;
        m_vec_rd   = 1'b0;
        m_align    = 1'b0;
        m_cause    = 2'd0;
        m_age      = 0;
        for (int i = 0; i < 8; i++) rd_hist[i] = 1'b0;
    endtask

    // Advance the model across the coming clock edge using current inputs
    task automatic modelStep();
        m_vec_rd = 1'b0;
        m_align  = 1'b0;
        if (m_age == 0) begin
            if (exc_req) begin
                m_cause    = (exc_cause == 2'd3) ? 2'd0 : exc_cause;
                m_epc      = m_pc - 32'd4;
                m_vec_rd   = 1'b1;
                m_vec_addr = 32'd253 + {30'b0, m_cause};
                m_age      = 1;
            end else if (pc_write || (pc_write_cond && modelTake(branch_op, zero, gt))) begin
                if (ALIGN_EN && pc_next[1:0] != 2'b00) m_align = 1'b1;
                else m_pc = pc_next;
            end
        end else if (m_age == MEM_LAT + 1) begin
            m_pc  = {24'b0, mem[m_cause]};
            m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic applyStimulus(input logic pw, input logic pwc, input logic [1:0] op,
                                 input logic z, input logic g, input logic [31:0] nxt,
                                 input logic er, input logic [1:0] cause);
        pc_write      = pw;
        pc_write_cond = pwc;
        branch_op     = op;
        zero          = z;
        gt            = g;
        pc_next       = nxt;
        exc_req       = er;
        exc_cause     = cause;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    endtask

    // Called at a negedge with inputs set: act as memory (data valid
    // MEM_LAT cycles after vec_rd, junk otherwise), step model, wait a cycle
    task automatic runCycle();
        for (int i = 7; i > 0; i--) rd_hist[i] = rd_hist[i-1];
        rd_hist[0] = vec_rd;
        if (rd_hist[MEM_LAT] && vec_addr >= 32'd253 && vec_addr <= 32'd255)
            vec_byte = mem[vec_addr[1:0] - 2'd1];
        else
            vec_byte = ~mem[m_cause];
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset(input bit checkNow);
        reset = 1'b1;
        #1;
        if (checkNow) begin
            checkOutput("async reset pc", pc, RESET_PC);
            checkOutput("async reset epc", epc, 32'h0);
            checkBit("async reset exc_busy", exc_busy, 1'b0);
        end
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Compare process: outputs settle shortly after each rising edge
    always @(posedge clk) begin
        #2;
        checkOutput("pc", pc, m_pc);
        checkOutput("epc", epc, m_epc);
        checkOutput("vec_addr", vec_addr, m_vec_addr);
        checkBit("vec_rd", vec_rd, m_vec_rd);
        checkBit("exc_busy", exc_busy, m_age != 0);
        checkBit("align_err", align_err, m_align);
    end

    initial begin
        logic [3:0]  takeIfOne;
        logic [3:0]  takeIfZero;
        logic        expTake;
        logic [31:0] expPc;

        reset = 1'b1;
        applyIdle();
        vec_byte = 8'h00;
        mem[0] = 8'hC4;
        mem[1] = 8'h7A;
        mem[2] = 8'h3C;
        modelReset();
        @(negedge clk);
        reset = 1'b0;

        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset epc", epc, 32'h0);
        checkOutput("reset vec_addr", vec_addr, 32'h0);
        checkBit("reset vec_rd", vec_rd, 1'b0);
        checkBit("reset exc_busy", exc_busy, 1'b0);
        checkBit("reset align_err", align_err, 1'b0);

        // Unconditional write then hold
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h40, 1'b0, 2'd0);
        runCycle();
        checkOutput("write pc", pc, 32'h40);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h99, 1'b0, 2'd0);
        runCycle();
        checkOutput("hold pc", pc, 32'h40);

        // Every branch op with its deciding flag at 0 and at 1
        takeIfOne  = 4'b1001;
        takeIfZero = 4'b0110;
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 2; f++) begin
                applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h100, 1'b0, 2'd0);
                runCycle();
                if (op < 2)
                    applyStimulus(1'b0, 1'b1, 2'(op), f != 0, f == 0, 32'h80, 1'b0, 2'd0);
                else
                    applyStimulus(1'b0, 1'b1, 2'(op), f == 0, f != 0, 32'h80, 1'b0, 2'd0);
                runCycle();
                expTake = (f != 0) ? takeIfOne[op] : takeIfZero[op];
                expPc   = expTake ? 32'h80 : 32'h100;
                checkOutput($sformatf("branch op%0d flag%0d", op, f), pc, expPc);
            end
        end

        // Both strobes, branch not taken: write still happens
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 32'h10, 1'b0, 2'd0);
        runCycle();
        checkOutput("both strobes pc", pc, 32'h10);

        // Overflow exception colliding with a write, then a nested request
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h44, 1'b1, 2'b01);
        runCycle();
        checkOutput("ovf epc", epc, 32'hC);
        checkOutput("ovf vec_addr", vec_addr, 32'd254);
        checkBit("ovf vec_rd", vec_rd, 1'b1);
        checkOutput("ovf write dropped", pc, 32'h10);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h48, 1'b1, 2'b10);
        runCycle();
        checkBit("ovf vec_rd pulse", vec_rd, 1'b0);
        checkOutput("nested epc", epc, 32'hC);
        checkOutput("nested vec_addr", vec_addr, 32'd254);
        applyIdle();
        for (int i = 0; i < MEM_LAT - 1; i++) runCycle();
        checkOutput("ovf pc before load", pc, 32'h10);
        checkBit("ovf busy in load", exc_busy, 1'b1);
        runCycle();
        checkOutput("ovf handler pc", pc, 32'h7A);
        checkBit("ovf busy done", exc_busy, 1'b0);

        // Reserved cause uses the first vector byte; pc=0x7A -> epc=0x76
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 2'b11);
        runCycle();
        checkOutput("rsvd vec_addr", vec_addr, 32'd253);
        checkOutput("rsvd epc", epc, 32'h76);
        applyIdle();
        for (int i = 0; i < MEM_LAT + 1; i++) runCycle();
        checkOutput("rsvd handler pc", pc, 32'hC4);

        // Misaligned write
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h200, 1'b0, 2'd0);
        runCycle();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h42, 1'b0, 2'd0);
        runCycle();
        if (ALIGN_EN) begin
            checkOutput("align pc kept", pc, 32'h200);
            checkBit("align_err pulse", align_err, 1'b1);
        end else begin
            checkOutput("unaligned pc", pc, 32'h42);
            checkBit("align_err tied", align_err, 1'b0);
        end
        applyIdle();
        runCycle();
        checkBit("align_err cleared", align_err, 1'b0);

        // Reset in the middle of an exception sequence
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 2'b10);
        runCycle();
        applyIdle();
        runCycle();
        doReset(1'b1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] nxt;
            nxt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 199) == 0) begin
                doReset(1'b1);
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                              2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1, nxt,
                              $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 63) == 0) mem[$urandom_range(0, 2)] = 8'($urandom);
                runCycle();
            end
        end

        applyIdle();
        for (int i = 0; i < MEM_LAT + 3; i++) runCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
